// File: rtl/sd_byte_player_ctrl.sv
// sd_byte_player_ctrl
//   Sequences the SD file-reader datapath. It pulses the reader's active-low
//   reset, captures the reader's byte stream into an on-chip buffer, and
//   declares the load complete after an idle timeout. It then serves the
//   buffered bytes one at a time to a two-digit hex display under next/prev
//   button control.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   start                  level key; rising edge starts/restarts a load
//   btn_next, btn_prev     level keys; rising edges step the displayed byte
//   sd_rstn                active-low reset to the file reader
//   sd_outen, sd_outbyte   reader byte strobe and data
//   digit_high, digit_low  displayed byte, upper/lower nibble
//   byte_index             index of the displayed byte
//   byte_count             bytes stored (0..2**DEPTH_LOG2)
//   state                  0=IDLE 1=RESET_SD 2=LOAD 3=READY
//   overflow               sticky, a byte arrived while the buffer was full
//
// Optional build macro AUTOPLAY_EN: in READY the index auto-advances every
// AUTO_PERIOD cycles and wraps at the last byte. Without it, the index moves
// only on buttons.
module sd_byte_player_ctrl #(
   parameter int DEPTH_LOG2   = 9,
   parameter int RESET_HOLD   = 16,
   parameter int IDLE_TIMEOUT = 1_000_000,
   parameter int AUTO_PERIOD  = 25_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  btn_next,
   input  logic                  btn_prev,
   output logic                  sd_rstn,
   input  logic                  sd_outen,
   input  logic [7:0]            sd_outbyte,
   output logic [3:0]            digit_high,
   output logic [3:0]            digit_low,
   output logic [DEPTH_LOG2-1:0] byte_index,
   output logic [DEPTH_LOG2:0]   byte_count,
   output logic [1:0]            state,
   output logic                  overflow
);
   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_RESET_SD = 2'd1;
   localparam logic [1:0] S_LOAD     = 2'd2;
   localparam logic [1:0] S_READY    = 2'd3;

   localparam int CW = DEPTH_LOG2 + 1;
   localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam logic [CW-1:0] DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [1:0]            state_q, state_d;
   logic [HW-1:0]         hold_q, hold_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DEPTH_LOG2-1:0] index_q, index_d;
   logic [7:0]            dig_q, dig_d;
   logic                  ovf_q, ovf_d;
   logic                  start_h_q, next_h_q, prev_h_q, outen_h_q;
   logic                  rd_retry_q, rd_vld_q;
   logic [7:0]            rd_data_q;
   logic [7:0]            mem_q [0:(1<<DEPTH_LOG2)-1];

   logic start_ev, next_ev, prev_ev, outen_ev;
   logic nav_ok, step_next, step_prev;
   logic wr_en, rd_req, rd_en;
   logic [CW-1:0] idx_ext, idx_inc;

`ifdef AUTOPLAY_EN
   localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
   logic [AW-1:0] auto_q, auto_d;
`endif

   assign start_ev = start & ~start_h_q;
   assign next_ev  = btn_next & ~next_h_q;
   assign prev_ev  = btn_prev & ~prev_h_q;
   assign outen_ev = sd_outen & ~outen_h_q;

   assign idx_ext   = {1'b0, index_q};
   assign idx_inc   = idx_ext + CW'(1);
   assign nav_ok    = (state_q == S_LOAD) || (state_q == S_READY);
   // Simultaneous next and prev cancel each other.
   assign step_next = nav_ok & next_ev & ~prev_ev & (idx_inc < count_q);
   assign step_prev = nav_ok & prev_ev & ~next_ev & (index_q != '0);

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      timer_d = timer_q;
      count_d = count_q;
      index_d = index_q;
      dig_d   = dig_q;
      ovf_d   = ovf_q;
      wr_en   = 1'b0;
      rd_req  = rd_retry_q;
`ifdef AUTOPLAY_EN
      auto_d  = '0;
`endif
      if (rd_vld_q) dig_d = rd_data_q;

      case (state_q)
         S_RESET_SD: begin
            if (hold_q == HW'(RESET_HOLD - 1)) state_d = S_LOAD;
            else                               hold_d  = hold_q + HW'(1);
         end
         S_LOAD: begin
            if (outen_ev) begin
               timer_d = '0;
               if (count_q < DEPTH_C) begin
                  wr_en   = 1'b1;
                  count_d = count_q + CW'(1);
                  // First byte bypasses the RAM so it shows immediately.
                  if (count_q == '0) dig_d = sd_outbyte;
               end else begin
                  ovf_d = 1'b1;
               end
            end else if (count_q != '0) begin
               if (timer_q == TW'(IDLE_TIMEOUT - 1)) state_d = S_READY;
               else                                  timer_d = timer_q + TW'(1);
            end
         end
         default: ;
      endcase

      if (step_next) begin
         index_d = idx_inc[DEPTH_LOG2-1:0];
         rd_req  = 1'b1;
      end else if (step_prev) begin
         index_d = index_q - DEPTH_LOG2'(1);
         rd_req  = 1'b1;
      end

`ifdef AUTOPLAY_EN
      if (state_q == S_READY && !(next_ev || prev_ev) && count_q > CW'(1)) begin
         if (auto_q == AW'(AUTO_PERIOD - 1)) begin
            index_d = (idx_inc >= count_q) ? '0 : idx_inc[DEPTH_LOG2-1:0];
            rd_req  = 1'b1;
         end else begin
            auto_d = auto_q + AW'(1);
         end
      end
`endif

      // Restart wins over everything else in LOAD/READY; ignored mid-reset.
      if (start_ev && state_q != S_RESET_SD) begin
         state_d = S_RESET_SD;
         hold_d  = '0;
         timer_d = '0;
         count_d = '0;
         index_d = '0;
         dig_d   = '0;
         ovf_d   = 1'b0;
         wr_en   = 1'b0;
         rd_req  = 1'b0;
`ifdef AUTOPLAY_EN
         auto_d  = '0;
`endif
      end
   end

   // Single RAM port: a write blocks the read, which retries next cycle.
   assign rd_en = rd_req & ~wr_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         hold_q     <= '0;
         timer_q    <= '0;
         count_q    <= '0;
         index_q    <= '0;
         dig_q      <= '0;
         ovf_q      <= 1'b0;
         start_h_q  <= 1'b0;
         next_h_q   <= 1'b0;
         prev_h_q   <= 1'b0;
         outen_h_q  <= 1'b0;
         rd_retry_q <= 1'b0;
         rd_vld_q   <= 1'b0;
`ifdef AUTOPLAY_EN
         auto_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         timer_q    <= timer_d;
         count_q    <= count_d;
         index_q    <= index_d;
         dig_q      <= dig_d;
         ovf_q      <= ovf_d;
         start_h_q  <= start;
         next_h_q   <= btn_next;
         prev_h_q   <= btn_prev;
         outen_h_q  <= sd_outen;
         rd_retry_q <= rd_req & wr_en;
         rd_vld_q   <= rd_en;
`ifdef AUTOPLAY_EN
         auto_q     <= auto_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)      mem_q[count_q[DEPTH_LOG2-1:0]] <= sd_outbyte;
      else if (rd_en) rd_data_q <= mem_q[index_d];
   end

   assign sd_rstn    = (state_q == S_LOAD) || (state_q == S_READY);
   assign state      = state_q;
   assign digit_high = dig_q[7:4];
   assign digit_low  = dig_q[3:0];
   assign byte_index = index_q;
   assign byte_count = count_q;
   assign overflow   = ovf_q;
endmodule

// File: doc/sd_byte_player_ctrl.md
Name: sd_byte_player_ctrl

Overview:
- Sequences the SD file-reader datapath: pulses the reader's active-low reset, captures its byte stream into an on-chip buffer, and detects end-of-file by an idle timeout.
- Serves the buffered bytes one at a time to the two-digit hex display under next/prev button control.
- Sits between sd_file_reader, the debounced keys and driver_DigitalTubeHexHex.

Parameters:
- DEPTH_LOG2, 9, buffer depth = 2**DEPTH_LOG2 bytes (512).
- RESET_HOLD, 16, cycles sd_rstn is held low in RESET_SD (min 1).
- IDLE_TIMEOUT, 1_000_000, cycles with no new byte after the first byte before load is declared complete.
- AUTO_PERIOD, 25_000_000, auto-advance interval; used only with AUTOPLAY_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  debounced key, level; rising edge starts or restarts a load
- btn_next  in  1  debounced key, level; rising edge advances the display
- btn_prev  in  1  debounced key, level; rising edge steps the display back
- sd_rstn  out  1  active-low reset to sd_file_reader
- sd_outen  in  1  reader byte strobe
- sd_outbyte  in  8  reader data
- digit_high  out  4  displayed byte [7:4]
- digit_low  out  4  displayed byte [3:0]
- byte_index  out  DEPTH_LOG2  index of the displayed byte
- byte_count  out  DEPTH_LOG2+1  bytes stored (0..2**DEPTH_LOG2)
- state  out  2  0=IDLE 1=RESET_SD 2=LOAD 3=READY
- overflow  out  1  sticky; set when a byte arrives while the buffer is full

Behaviour:
- Reset values:
  - state=IDLE, sd_rstn=0.
  - All counters, digits, index and count = 0; overflow=0.
  - Edge-detect history registers = 0.
- Edge detection: start, btn_next, btn_prev and sd_outen each have a 1-flop history. An event is current=1 with prev=0.
- IDLE:
  - sd_rstn=0.
  - Start edge goes to RESET_SD and clears count, index, digits and overflow.
- RESET_SD:
  - sd_rstn=0 for exactly RESET_HOLD cycles, then go to LOAD.
  - sd_rstn=1 from the first LOAD cycle.
- LOAD, on an sd_outen edge:
  - If count < depth: write the byte to buf[count] and increment count.
  - Otherwise: drop the byte and set overflow.
  - The first byte (count==0) is also loaded directly into digit_high/low on the same edge, so the digits are visible the cycle after the strobe; index stays 0.
- LOAD idle timer:
  - Starts only after the first byte.
  - Cleared on every sd_outen edge, including dropped bytes.
  - On reaching IDLE_TIMEOUT, go to READY.
  - With no bytes at all the block stays in LOAD indefinitely; a new start edge recovers it.
- READY: sd_rstn stays 1. A start edge goes to RESET_SD and performs the same clears as from IDLE.
- Navigation (LOAD and READY only; ignored in IDLE and RESET_SD):
  - Next edge: if index+1 < count, increment index; otherwise hold (no wrap).
  - Prev edge: if index > 0, decrement index; otherwise hold.
  - Next and prev edges in the same cycle: no change.
- Buffer:
  - Single-port synchronous RAM, 1-cycle read latency.
  - On an accepted step, digits update 2 cycles after the edge-detect cycle; byte_index updates 1 cycle after it.
  - A LOAD write and a read in the same cycle: the write has priority and the read retries the next cycle (one extra cycle of latency).
- Start-edge priority:
  - A start edge in LOAD or READY restarts and overrides any navigation in that cycle.
  - A start edge in RESET_SD is ignored.
- rst overrides everything, in every state.
- Arithmetic: all counters are unsigned and saturate or clamp as stated above; none wrap.

Optional Feature:
- Macro: AUTOPLAY_EN.
- Defined:
  - In READY with no button edge, a counter advances the index every AUTO_PERIOD cycles.
  - At count-1 the index wraps to 0.
  - Any next/prev edge restarts the auto counter.
  - count ≤ 1: no auto-advance.
- Undefined:
  - No auto counter logic.
  - The index changes only on buttons.

Test Plan:
- rst, then start edge → state goes 1 for 16 cycles with sd_rstn=0, then state=2 with sd_rstn=1.
- LOAD 3 strobes of 0x3A, 0x5C, 0x01 → after the first strobe, digits=3/A; count=3; IDLE_TIMEOUT cycles after the last strobe, state=3.
- READY with count=3: next, next, next → index 1, 2, 2 with digits 0/1; prev ×3 → index 1, 0, 0 with digits 3/A.
- 513 strobes → count=512 and overflow=1; buf[511] holds byte 511; byte 512 is dropped.
- next and prev in the same cycle → index unchanged; start in READY → count=0, digits=0, state=1.
- rst asserted mid-LOAD → all outputs at reset values the next cycle; sd_rstn=0.
